// File: rtl/code_checker.sv
// Four-digit keypad passcode checker with retry counting and alarm lockout.
// Define LOCKOUT_TIMER_EN to release the alarm after LOCK_CYCLES cycles.
module code_checker #(
    parameter int MAX_TRIES     = 3,
    parameter int UNLOCK_CYCLES = 8,
    parameter int LOCK_CYCLES   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit,
    input  logic        digit_valid,
    input  logic        clear,
    input  logic [15:0] stored_code,
    output logic        unlock,
    output logic        fail,
    output logic        alarm,
    output logic [1:0]  tries,
    output logic [2:0]  entry_count
);

    // One hold timer serves both the unlock window and the lockout window
    localparam int TMAX = (UNLOCK_CYCLES > LOCK_CYCLES) ?
                          UNLOCK_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [1:0]    MAXT     = 2'(MAX_TRIES);
    localparam logic [TW-1:0] UNL_LAST = TW'(UNLOCK_CYCLES - 1);
`ifdef LOCKOUT_TIMER_EN
    localparam logic [TW-1:0] LCK_LAST = TW'(LOCK_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        UNLOCKED,
        FAIL,
        ALARM
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          mis_q, mis_d;
    logic [1:0]    tries_q, tries_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [3:0]    nib;
    logic          ne;

    // Nibble for the digit about to be captured, read live
    always_comb begin
        nib = stored_code[3:0];
        unique case (cnt_q[1:0])
            2'd0: nib = stored_code[15:12];
            2'd1: nib = stored_code[11:8];
            2'd2: nib = stored_code[7:4];
            2'd3: nib = stored_code[3:0];
            default: nib = stored_code[3:0];
        endcase
    end

    assign ne = (digit != nib);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        tries_d = tries_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (digit_valid) begin
                    state_d = ENTRY;
                    cnt_d   = 3'd1;
                    mis_d   = ne;
                end
            end
            ENTRY: begin
                if (clear) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    mis_d   = 1'b0;
                end else if (digit_valid) begin
                    mis_d = mis_q | ne;
                    if (cnt_q == 3'd3) begin
                        state_d = CHECK;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            CHECK: begin
                timer_d = '0;
                mis_d   = 1'b0;
                if (mis_q) begin
                    state_d = FAIL;
                    tries_d = tries_q + 2'd1;
                end else begin
                    state_d = UNLOCKED;
                    tries_d = 2'd0;
                end
            end
            UNLOCKED: begin
                if (timer_q == UNL_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            FAIL: begin
                timer_d = '0;
                state_d = (tries_q >= MAXT) ? ALARM : IDLE;
            end
            ALARM: begin
`ifdef LOCKOUT_TIMER_EN
                if (timer_q == LCK_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                    tries_d = 2'd0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`else
                state_d = ALARM;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            mis_q   <= 1'b0;
            tries_q <= 2'd0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
        end
    end

    assign unlock      = (state_q == UNLOCKED);
    assign fail        = (state_q == FAIL);
    assign alarm       = (state_q == ALARM);
    assign tries       = tries_q;
    assign entry_count = cnt_q;

endmodule
